// File: rtl/adc_spi_capture.sv
// Serial capture front end for a multi-channel SPI ADC: a conversion strobe
// followed by one frame of sck bits, with per-channel gap bits dropped.
module adc_spi_capture #(
  parameter int DATA_W   = 14,
  parameter int CH_N     = 2,
  parameter int GAP_BITS = 2,
  parameter int SCK_DIV  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clockenable,
  input  logic                     miso,
  output logic                     adconv,
  output logic                     sck,
  output logic [CH_N*DATA_W-1:0]   datos,
  output logic                     ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CH_BITS    = GAP_BITS + DATA_W;
  localparam int FRAME_BITS = CH_N * CH_BITS;
  localparam int CYC_W      = $clog2(2 * SCK_DIV + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * SCK_DIV - 1);
  localparam logic [CYC_W-1:0] SCK_RISE = CYC_W'(SCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CYC_W-1:0]         cyc_q, cyc_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0]    shift_q, shift_d;
  logic [CH_N*DATA_W-1:0]   datos_q, datos_d;
  logic                     ce_prev_q, ce_prev_d;
  logic                     overrun_q, overrun_d;

  logic ce_rise;
  logic cyc_last;
  logic bit_last;

  assign ce_rise  = clockenable & ~ce_prev_q;
  assign cyc_last = (cyc_q == CYC_LAST);
  assign bit_last = (bit_q == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      datos_q   <= '0;
      ce_prev_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      datos_q   <= datos_d;
      ce_prev_q <= ce_prev_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ce_rise) state_d = CONV;
      CONV:    if (cyc_last) state_d = SHIFT;
      SHIFT:   if (cyc_last && bit_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first channel received sits in the top slot of the shift register;
  // each slot holds its gap bits above the data, so only the low DATA_W bits
  // of a slot are copied out. shift_d is used so a last bit sampled on the
  // final edge of the frame is already included.
  always_comb begin
    cyc_d     = '0;
    bit_d     = bit_q;
    shift_d   = shift_q;
    datos_d   = datos_q;
    ce_prev_d = clockenable;
    overrun_d = ce_rise && (state_q != IDLE);

    if ((state_q == CONV) || (state_q == SHIFT)) begin
      cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
    end

    if (state_q != SHIFT) begin
      bit_d = '0;
    end else if (cyc_last) begin
      bit_d = bit_q + BIT_W'(1);
    end

    if ((state_q == SHIFT) && (cyc_q == SCK_RISE)) begin
      shift_d = {shift_q[FRAME_BITS-2:0], miso};
    end

    if ((state_q == SHIFT) && cyc_last && bit_last) begin
      for (int k = 0; k < CH_N; k++) begin
        datos_d[k*DATA_W +: DATA_W] = shift_d[(CH_N-1-k)*CH_BITS +: DATA_W];
      end
    end
  end

  always_comb begin
    adconv  = (state_q == CONV);
    sck     = (state_q == SHIFT) && (cyc_q >= SCK_RISE);
    ready   = (state_q == DONE);
    busy    = (state_q != IDLE);
    datos   = datos_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: a converter model answers sck rising edges with
// frame bits built from random channel words and gap bits.
module tb_adc_spi_capture;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        ce_a = 1'b0;
  logic        miso_a = 1'b0;
  logic        adconv_a, sck_a, ready_a, busy_a, overrun_a;
  logic [27:0] datos_a;

  logic        ce_b = 1'b0;
  logic        miso_b = 1'b0;
  logic        adconv_b, sck_b, ready_b, busy_b, overrun_b;
  logic [11:0] datos_b;

  adc_spi_capture u_dut_a (
    .clock(clock), .reset(reset), .clockenable(ce_a), .miso(miso_a),
    .adconv(adconv_a), .sck(sck_a), .datos(datos_a), .ready(ready_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  adc_spi_capture #(.DATA_W(12), .CH_N(1), .GAP_BITS(0), .SCK_DIV(1)) u_dut_b (
    .clock(clock), .reset(reset), .clockenable(ce_b), .miso(miso_b),
    .adconv(adconv_b), .sck(sck_b), .datos(datos_b), .ready(ready_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  bit          frame_a[32];
  int          base_a = 0;
  logic [27:0] exp_a = '0;
  int          rise_a = 0, ready_cnt_a = 0, ready_at_a = -1, ov_cnt_a = 0;
  logic        sck_prev_a = 1'b0;

  bit          frame_b[12];
  int          base_b = 0;
  logic [11:0] exp_b = '0;
  int          rise_b = 0, ready_cnt_b = 0, ready_at_b = -1;
  logic        sck_prev_b = 1'b0;

  // Converter model: each sck rising edge presents the next frame bit.
  always @(negedge clock) begin
    if (sck_a && !sck_prev_a) begin
      if ((rise_a - base_a >= 0) && (rise_a - base_a < 32)) miso_a = frame_a[rise_a - base_a];
      else miso_a = 1'b0;
      rise_a = rise_a + 1;
    end
    sck_prev_a = sck_a;
    if (ready_a) begin ready_cnt_a = ready_cnt_a + 1; ready_at_a = cyc; end
    if (overrun_a) ov_cnt_a = ov_cnt_a + 1;

    if (sck_b && !sck_prev_b) begin
      if ((rise_b - base_b >= 0) && (rise_b - base_b < 12)) miso_b = frame_b[rise_b - base_b];
      else miso_b = 1'b0;
      rise_b = rise_b + 1;
    end
    sck_prev_b = sck_b;
    if (ready_b) begin ready_cnt_b = ready_cnt_b + 1; ready_at_b = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic step(input int n);
    step_to(cyc + n);
  endtask

  // Transmission order: channel 0 gap bits, channel 0 data MSB first, then channel 1.
  task automatic load_frame_a(input logic [13:0] d0, input logic [13:0] d1,
                              input logic [1:0] g0, input logic [1:0] g1);
    logic [15:0] c0, c1;
    c0 = {g0, d0};
    c1 = {g1, d1};
    for (int i = 0; i < 16; i++) begin
      frame_a[i]      = c0[15-i];
      frame_a[16 + i] = c1[15-i];
    end
    exp_a  = {d1, d0};
    base_a = rise_a;
  endtask

  task automatic load_random_a();
    load_frame_a(14'($urandom), 14'($urandom), 2'($urandom), 2'($urandom));
  endtask

  task automatic run_frame_a(input string tag);
    int t, r0, o0, s0;
    r0 = ready_cnt_a; o0 = ov_cnt_a; s0 = rise_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 1);
    ce_a = 1'b0;
    check({tag, " conv adconv"}, 64'(adconv_a), 64'(1));
    check({tag, " conv busy"}, 64'(busy_a), 64'(1));
    step_to(t + 4);
    check({tag, " conv end adconv"}, 64'(adconv_a), 64'(1));
    check({tag, " conv sck"}, 64'(sck_a), 64'(0));
    step_to(t + 5);
    check({tag, " shift adconv"}, 64'(adconv_a), 64'(0));
    check({tag, " shift sck low"}, 64'(sck_a), 64'(0));
    step_to(t + 7);
    check({tag, " shift sck high"}, 64'(sck_a), 64'(1));
    step_to(t + 133);
    check({tag, " ready"}, 64'(ready_a), 64'(1));
    check({tag, " datos"}, 64'(datos_a), 64'(exp_a));
    step_to(t + 134);
    check({tag, " ready after"}, 64'(ready_a), 64'(0));
    check({tag, " busy after"}, 64'(busy_a), 64'(0));
    check({tag, " ready count"}, 64'(ready_cnt_a - r0), 64'(1));
    check({tag, " ready cycle"}, 64'(ready_at_a), 64'(t + 133));
    check({tag, " sck rises"}, 64'(rise_a - s0), 64'(32));
    check({tag, " no overrun"}, 64'(ov_cnt_a - o0), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, t2, r0, o0, s0;
    reset = 1'b1;
    step(3);
    check("reset adconv", 64'(adconv_a), 64'(0));
    check("reset sck", 64'(sck_a), 64'(0));
    check("reset datos", 64'(datos_a), 64'(0));
    check("reset ready", 64'(ready_a), 64'(0));
    check("reset busy", 64'(busy_a), 64'(0));
    check("reset overrun", 64'(overrun_a), 64'(0));
    check("reset busy b", 64'(busy_b), 64'(0));
    check("reset datos b", 64'(datos_b), 64'(0));
    reset = 1'b0;
    step(2);

    load_frame_a(14'h2AAA, 14'h1555, 2'b00, 2'b00);
    run_frame_a("pattern");
    check("pattern literal", 64'(datos_a), 64'(28'h5556AAA));
    step(3);

    load_frame_a(14'h3FFF, 14'h3FFF, 2'b11, 2'b11);
    run_frame_a("ones");
    step(3);

    for (int i = 0; i < 3; i++) begin
      load_random_a();
      run_frame_a($sformatf("random%0d", i));
      step(1 + int'($urandom_range(0, 4)));
    end

    // Second request mid-frame is dropped with an overrun pulse.
    load_random_a();
    r0 = ready_cnt_a; o0 = ov_cnt_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 1);
    ce_a = 1'b0;
    step_to(t + 50);
    ce_a = 1'b1;
    step_to(t + 51);
    check("ovr pulse", 64'(overrun_a), 64'(1));
    step_to(t + 52);
    check("ovr pulse end", 64'(overrun_a), 64'(0));
    ce_a = 1'b0;
    step_to(t + 133);
    check("ovr ready", 64'(ready_a), 64'(1));
    check("ovr datos", 64'(datos_a), 64'(exp_a));
    step_to(t + 134);
    check("ovr ready count", 64'(ready_cnt_a - r0), 64'(1));
    check("ovr count", 64'(ov_cnt_a - o0), 64'(1));
    check("ovr busy after", 64'(busy_a), 64'(0));
    step(3);

    // Edge in the DONE cycle counts as overrun and does not start a frame.
    load_random_a();
    o0 = ov_cnt_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 1);
    ce_a = 1'b0;
    step_to(t + 133);
    check("done-edge ready", 64'(ready_a), 64'(1));
    ce_a = 1'b1;
    step_to(t + 134);
    check("done-edge overrun", 64'(overrun_a), 64'(1));
    check("done-edge busy", 64'(busy_a), 64'(0));
    step_to(t + 136);
    check("done-edge no start", 64'(busy_a), 64'(0));
    check("done-edge ovr count", 64'(ov_cnt_a - o0), 64'(1));
    ce_a = 1'b0;
    step(3);

    // Edge on the first IDLE cycle starts a new frame.
    load_random_a();
    r0 = ready_cnt_a; o0 = ov_cnt_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 1);
    ce_a = 1'b0;
    step_to(t + 134);
    base_a = rise_a;
    ce_a = 1'b1;
    t2 = t + 134;
    step_to(t2 + 1);
    ce_a = 1'b0;
    check("idle-edge busy", 64'(busy_a), 64'(1));
    check("idle-edge adconv", 64'(adconv_a), 64'(1));
    step_to(t2 + 133);
    check("idle-edge ready", 64'(ready_a), 64'(1));
    check("idle-edge datos", 64'(datos_a), 64'(exp_a));
    step_to(t2 + 134);
    check("idle-edge ready count", 64'(ready_cnt_a - r0), 64'(2));
    check("idle-edge no overrun", 64'(ov_cnt_a - o0), 64'(0));
    step(3);

    // Request held high yields a single frame.
    load_random_a();
    r0 = ready_cnt_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 133);
    check("held ready", 64'(ready_a), 64'(1));
    check("held datos", 64'(datos_a), 64'(exp_a));
    step_to(t + 1000);
    check("held busy", 64'(busy_a), 64'(0));
    check("held ready count", 64'(ready_cnt_a - r0), 64'(1));
    check("held ready cycle", 64'(ready_at_a), 64'(t + 133));
    ce_a = 1'b0;
    step(3);

    // Reset in the middle of the shift phase.
    load_random_a();
    r0 = ready_cnt_a;
    t = cyc;
    ce_a = 1'b1;
    step_to(t + 1);
    ce_a = 1'b0;
    step_to(t + 60);
    check("midreset sck before", 64'(sck_a), 64'(1));
    reset = 1'b1;
    #1;
    check("midreset adconv", 64'(adconv_a), 64'(0));
    check("midreset sck", 64'(sck_a), 64'(0));
    check("midreset busy", 64'(busy_a), 64'(0));
    check("midreset datos", 64'(datos_a), 64'(0));
    step(2);
    reset = 1'b0;
    step(150);
    check("midreset no ready", 64'(ready_cnt_a - r0), 64'(0));
    check("midreset idle", 64'(busy_a), 64'(0));
    check("midreset datos held", 64'(datos_a), 64'(0));

    // Request already high when reset releases starts a frame.
    reset = 1'b1;
    ce_a = 1'b1;
    load_random_a();
    step(2);
    reset = 1'b0;
    t = cyc;
    step_to(t + 1);
    check("release busy", 64'(busy_a), 64'(1));
    step_to(t + 133);
    check("release ready", 64'(ready_a), 64'(1));
    check("release datos", 64'(datos_a), 64'(exp_a));
    step_to(t + 134);
    check("release busy after", 64'(busy_a), 64'(0));
    ce_a = 1'b0;
    step(3);

    // Narrow configuration, single channel, no gap, fastest sck.
    exp_b = 12'hA5C;
    for (int i = 0; i < 12; i++) frame_b[i] = exp_b[11-i];
    base_b = rise_b;
    r0 = ready_cnt_b; s0 = rise_b;
    t = cyc;
    ce_b = 1'b1;
    step_to(t + 1);
    ce_b = 1'b0;
    check("b busy", 64'(busy_b), 64'(1));
    step_to(t + 27);
    check("b ready", 64'(ready_b), 64'(1));
    check("b datos", 64'(datos_b), 64'(12'hA5C));
    step_to(t + 28);
    check("b ready after", 64'(ready_b), 64'(0));
    check("b busy after", 64'(busy_b), 64'(0));
    check("b ready count", 64'(ready_cnt_b - r0), 64'(1));
    check("b ready cycle", 64'(ready_at_b), 64'(t + 27));
    check("b sck rises", 64'(rise_b - s0), 64'(12));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_spi_capture.md
ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Interface
REQ-001 Parameter DATA_W, default 14, bits per channel sample (legal 8..16).
REQ-002 Parameter CH_N, default 2, channels per frame (legal 1..4).
REQ-003 Parameter GAP_BITS, default 2, discarded sck bits before each channel's data (legal 0..4).
REQ-004 Parameter SCK_DIV, default 2, clock cycles per sck half-period (legal >=1).
REQ-005 clock  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clockenable  in  1  sample request; rising edge (1 now, 0 previous cycle) starts a frame.
REQ-008 miso  in  1  serial data from converter, MSB first.
REQ-009 adconv  out  1  conversion strobe to converter.
REQ-010 sck  out  1  serial clock to converter; idles low.
REQ-011 datos  out  CH_N*DATA_W  last complete frame; channel k at [k*DATA_W +: DATA_W].
REQ-012 ready  out  1  one-cycle pulse when datos updates.
REQ-013 busy  out  1  high while a frame is in progress.
REQ-014 overrun  out  1  one-cycle pulse when a request is dropped.

Function
REQ-015 FRAME_BITS SHALL equal CH_N*(GAP_BITS+DATA_W); default 32.
REQ-016 States: IDLE, CONV, SHIFT, DONE; busy=1 in CONV, SHIFT, DONE.
REQ-017 IDLE -> CONV on the cycle after a clockenable rising edge is detected (detect cycle = T).
REQ-018 CONV: adconv=1, sck=0 for exactly 2*SCK_DIV cycles, then -> SHIFT.
REQ-019 SHIFT: adconv=0; per bit, sck low SCK_DIV cycles then high SCK_DIV cycles; FRAME_BITS bits total.
REQ-020 miso SHALL be sampled in the cycle sck is driven 0->1; bits at gap positions discarded.
REQ-021 Frame order: channel 0 (gap bits, then DATA_W data bits MSB first), then channel 1, and so on.
REQ-022 After the last bit -> DONE for one cycle: all channels written to datos simultaneously, ready=1, sck=0; then -> IDLE.
REQ-023 ready SHALL assert at cycle T+1+2*SCK_DIV*(1+FRAME_BITS); default T+133.
REQ-024 datos SHALL hold its value between frames; partial shift data is never visible on datos.
REQ-025 A clockenable rising edge while busy=1 SHALL pulse overrun for one cycle, without restarting or extending the frame.
REQ-026 clockenable held high SHALL start only one frame; a new frame needs a fresh rising edge.
REQ-027 A rising edge in the DONE cycle counts as an overrun; an edge on the first IDLE cycle starts a frame.

Reset
REQ-028 While reset=1, asynchronously: state IDLE, adconv=0, sck=0, datos=0, ready=0, busy=0, overrun=0, edge-detect history=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no ready pulse; datos cleared.
REQ-030 After reset deasserts, clockenable already high SHALL count as a rising edge (history=0).

Verification
REQ-031 Defaults; assert reset during SHIFT -> adconv, sck, busy, datos go to 0 within the same cycle, no ready afterwards.
REQ-032 Defaults; miso frame = 2'b00,14'h2AAA,2'b00,14'h1555 -> ready at T+133, datos=28'h5556AAA (ch1=14'h1555, ch0=14'h2AAA).
REQ-033 Defaults; miso held at 1 -> datos=28'hFFFFFFF, gap bits have no effect; 32 sck rising edges counted.
REQ-034 Defaults; second clockenable rising edge at T+50 -> overrun pulse of one cycle, exactly one ready at T+133.
REQ-035 Defaults; clockenable held high 1000 cycles -> exactly one frame, one ready pulse, busy low after T+133.
REQ-036 DATA_W=12, CH_N=1, GAP_BITS=0, SCK_DIV=1; miso pattern 12'hA5C -> ready at T+27, datos=12'hA5C.
